clock_alarm_ctrl: RTL and testbench

//  Alarm controller that sits directly downstream of digital_clock.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/sec_tick_detect.sv | 23 ++
 rtl/clock_alarm_ctrl.sv | 151 +++++++++++++++
 tb/tb_clock_alarm_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day types and limits for the clock top level and its alarm logic.
package clock_pkg;

    localparam int unsigned TIME_W  = 6;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned SNZ_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RINGING,
        SNOOZE
    } alarm_state_e;

    typedef struct packed {
        logic [TIME_W-1:0] min;
        logic [TIME_W-1:0] sec;
    } alarm_time_t;

    // True when both fields are legal wall-clock values.
    function automatic logic time_valid(input logic [TIME_W-1:0] m, input logic [TIME_W-1:0] s);
        return (m <= TIME_W'(MIN_MAX)) && (s <= TIME_W'(SEC_MAX));
    endfunction

endpackage

// File: rtl/sec_tick_detect.sv
// Flags any change of the upstream seconds value, including 59->0 rollover and upstream resets.
module sec_tick_detect
    import clock_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [TIME_W-1:0] seconds,
    output logic              sec_tick
);

    logic [TIME_W-1:0] seconds_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seconds_q <= '0;
        end else begin
            seconds_q <= seconds;
        end
    end

    assign sec_tick = (seconds != seconds_q);

endmodule

// File: rtl/clock_alarm_ctrl.sv
// Alarm controller downstream of digital_clock: match, ring, snooze, dismiss and auto-timeout.
module clock_alarm_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned RING_SECONDS   = 30,
    parameter int unsigned SNOOZE_SECONDS = 300,
    parameter int unsigned MAX_SNOOZES    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TIME_W-1:0]    seconds,
    input  logic [TIME_W-1:0]    minutes,
    input  logic [TIME_W-1:0]    alarm_min_in,
    input  logic [TIME_W-1:0]    alarm_sec_in,
    input  logic                 alarm_load,
    input  logic                 alarm_enable,
    input  logic                 snooze,
    input  logic                 dismiss,
    output logic                 ringing,
    output logic                 armed,
    output logic [SNZ_CNT_W-1:0] snooze_count,
    output logic                 missed,
    output logic                 load_err
);

    localparam int unsigned RING_W = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
    localparam int unsigned SNZ_W  = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;

    localparam logic [RING_W-1:0]    RING_LAST    = RING_W'(RING_SECONDS - 1);
    localparam logic [SNZ_W-1:0]     SNZ_LAST     = SNZ_W'(SNOOZE_SECONDS - 1);
    localparam logic [SNZ_CNT_W-1:0] SNOOZE_LIMIT = SNZ_CNT_W'(MAX_SNOOZES);

    alarm_state_e         state, state_d;
    logic [RING_W-1:0]    ring_cnt, ring_cnt_d;
    logic [SNZ_W-1:0]     snz_cnt, snz_cnt_d;
    logic [SNZ_CNT_W-1:0] snooze_count_d;
    logic                 missed_d;
    alarm_time_t          alarm_q;
    logic                 sec_tick;
    logic                 match_c;
    logic                 load_ok_c;

    sec_tick_detect u_sec_tick (
        .clk      (clk),
        .reset    (reset),
        .seconds  (seconds),
        .sec_tick (sec_tick)
    );

    // Match only on the tick edge so a held time cannot re-trigger.
    assign match_c   = sec_tick && (seconds == alarm_q.sec) && (minutes == alarm_q.min);
    assign load_ok_c = time_valid(alarm_min_in, alarm_sec_in);

    // Next-state and counter update; enable beats dismiss beats snooze beats tick events.
    always_comb begin
        state_d        = state;
        ring_cnt_d     = ring_cnt;
        snz_cnt_d      = snz_cnt;
        snooze_count_d = snooze_count;
        missed_d       = 1'b0;

        if (!alarm_enable) begin
            state_d        = IDLE;
            ring_cnt_d     = '0;
            snz_cnt_d      = '0;
            snooze_count_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (match_c) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state_d        = ARMED;
                        snooze_count_d = '0;
                    end else if (snooze && (snooze_count < SNOOZE_LIMIT)) begin
                        state_d        = SNOOZE;
                        snooze_count_d = snooze_count + SNZ_CNT_W'(1);
                        snz_cnt_d      = '0;
                    end else if (sec_tick) begin
                        // Terminal count holds; leaving the state is what ends it.
                        if (ring_cnt == RING_LAST) begin
                            state_d        = ARMED;
                            missed_d       = 1'b1;
                            snooze_count_d = '0;
                        end else begin
                            ring_cnt_d = ring_cnt + RING_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        state_d        = ARMED;
                        snooze_count_d = '0;
                    end else if (sec_tick) begin
                        if (snz_cnt == SNZ_LAST) begin
                            state_d    = RINGING;
                            ring_cnt_d = '0;
                        end else begin
                            snz_cnt_d = snz_cnt + SNZ_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ring_cnt     <= '0;
            snz_cnt      <= '0;
            snooze_count <= '0;
            missed       <= 1'b0;
            ringing      <= 1'b0;
            armed        <= 1'b0;
        end else begin
            state        <= state_d;
            ring_cnt     <= ring_cnt_d;
            snz_cnt      <= snz_cnt_d;
            snooze_count <= snooze_count_d;
            missed       <= missed_d;
            ringing      <= (state_d == RINGING);
            armed        <= (state_d != IDLE);
        end
    end

    // Alarm time register; out-of-range loads are rejected and flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_q  <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= alarm_load && !load_ok_c;
            if (alarm_load && load_ok_c) begin
                alarm_q <= '{min: alarm_min_in, sec: alarm_sec_in};
            end
        end
    end

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Directed plus randomized bench for clock_alarm_ctrl against a countdown-style reference model.
module tb_clock_alarm_ctrl;

    localparam int RING_S  = 30;
    localparam int SNZ_S   = 5;
    localparam int MAX_SNZ = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] seconds, minutes, alarm_min_in, alarm_sec_in;
    logic       alarm_load, alarm_enable, snooze, dismiss;
    logic       ringing, armed, missed, load_err;
    logic [1:0] snooze_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: flags plus remaining-seconds countdowns.
    bit m_on, m_ring, m_snz, m_missed, m_lerr;
    int m_ring_left, m_snz_left, m_snoozes, m_amin, m_asec, m_prev_sec;

    clock_alarm_ctrl #(
        .RING_SECONDS   (RING_S),
        .SNOOZE_SECONDS (SNZ_S),
        .MAX_SNOOZES    (MAX_SNZ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seconds      (seconds),
        .minutes      (minutes),
        .alarm_min_in (alarm_min_in),
        .alarm_sec_in (alarm_sec_in),
        .alarm_load   (alarm_load),
        .alarm_enable (alarm_enable),
        .snooze       (snooze),
        .dismiss      (dismiss),
        .ringing      (ringing),
        .armed        (armed),
        .snooze_count (snooze_count),
        .missed       (missed),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_on = 0; m_ring = 0; m_snz = 0; m_missed = 0; m_lerr = 0;
        m_ring_left = 0; m_snz_left = 0; m_snoozes = 0;
        m_amin = 0; m_asec = 0; m_prev_sec = 0;
    endfunction

    // One clock of alarm behaviour, using the inputs present at the coming edge.
    function automatic void model_step();
        bit tick, hit;
        tick = (int'(seconds) != m_prev_sec);
        hit  = tick && (int'(seconds) == m_asec) && (int'(minutes) == m_amin);
        m_missed = 0;
        m_lerr   = 0;
        if (alarm_load) begin
            if (alarm_min_in <= 6'd59 && alarm_sec_in <= 6'd59) begin
                m_amin = int'(alarm_min_in);
                m_asec = int'(alarm_sec_in);
            end else begin
                m_lerr = 1;
            end
        end
        if (!alarm_enable) begin
            m_on = 0; m_ring = 0; m_snz = 0; m_snoozes = 0;
        end else if (!m_on) begin
            m_on = 1;
        end else if (m_ring) begin
            if (dismiss) begin
                m_ring = 0; m_snoozes = 0;
            end else if (snooze && m_snoozes < MAX_SNZ) begin
                m_ring = 0; m_snz = 1; m_snoozes++; m_snz_left = SNZ_S;
            end else if (tick) begin
                m_ring_left--;
                if (m_ring_left == 0) begin
                    m_ring = 0; m_missed = 1; m_snoozes = 0;
                end
            end
        end else if (m_snz) begin
            if (dismiss) begin
                m_snz = 0; m_snoozes = 0;
            end else if (tick) begin
                m_snz_left--;
                if (m_snz_left == 0) begin
                    m_snz = 0; m_ring = 1; m_ring_left = RING_S;
                end
            end
        end else if (hit) begin
            m_ring = 1; m_ring_left = RING_S;
        end
        m_prev_sec = int'(seconds);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string where);
        chk1({where, ":ringing"}, ringing, m_ring);
        chk1({where, ":armed"}, armed, m_on);
        chk2({where, ":snooze_count"}, snooze_count, 2'(m_snoozes));
        chk1({where, ":missed"}, missed, m_missed);
        chk1({where, ":load_err"}, load_err, m_lerr);
    endtask

    task automatic step(input string where);
        model_step();
        @(posedge clk);
        #1;
        check_model(where);
        alarm_load = 1'b0;
        snooze     = 1'b0;
        dismiss    = 1'b0;
    endtask

    task automatic advance();
        if (seconds == 6'd59) begin
            seconds = 6'd0;
            minutes = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        end else begin
            seconds = seconds + 6'd1;
        end
    endtask

    task automatic set_time(input logic [5:0] m, input logic [5:0] s, input string where);
        minutes = m;
        seconds = s;
        step(where);
    endtask

    initial begin
        reset = 1'b0;
        seconds = '0; minutes = '0; alarm_min_in = '0; alarm_sec_in = '0;
        alarm_load = 1'b0; alarm_enable = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        model_reset();
        #20;
        chk1("reset:ringing", ringing, 1'b0);
        chk1("reset:armed", armed, 1'b0);
        chk2("reset:snooze_count", snooze_count, 2'd0);
        chk1("reset:missed", missed, 1'b0);
        chk1("reset:load_err", load_err, 1'b0);
        reset = 1'b1;

        // Load 01:30, arm, approach and hit the match.
        alarm_enable = 1'b1;
        alarm_min_in = 6'd1; alarm_sec_in = 6'd30; alarm_load = 1'b1;
        step("t1_load");
        chk1("t1_armed_early", armed, 1'b1);
        set_time(6'd1, 6'd29, "t1_pre");
        chk1("t1_not_yet", ringing, 1'b0);
        set_time(6'd1, 6'd30, "t1_match");
        chk1("t1_ringing", ringing, 1'b1);
        chk1("t1_armed", armed, 1'b1);

        // No user action for the whole ring window.
        for (int i = 1; i <= RING_S; i++) begin
            advance();
            step("t2_tick");
            if (i == RING_S - 1) chk1("t2_still_ringing", ringing, 1'b1);
        end
        chk1("t2_fell", ringing, 1'b0);
        chk1("t2_missed", missed, 1'b1);
        chk1("t2_armed", armed, 1'b1);
        chk2("t2_count", snooze_count, 2'd0);
        step("t2_after");
        chk1("t2_missed_once", missed, 1'b0);

        // Snooze three times, then a fourth request is ignored.
        set_time(6'd1, 6'd29, "t3_pre");
        set_time(6'd1, 6'd30, "t3_match");
        for (int k = 1; k <= MAX_SNZ; k++) begin
            snooze = 1'b1;
            step("t3_snooze");
            chk1("t3_quiet", ringing, 1'b0);
            chk2("t3_count", snooze_count, 2'(k));
            for (int i = 1; i <= SNZ_S; i++) begin
                advance();
                step("t3_wait");
                if (i == SNZ_S - 1) chk1("t3_not_early", ringing, 1'b0);
            end
            chk1("t3_rering", ringing, 1'b1);
        end
        snooze = 1'b1;
        step("t3_fourth");
        chk1("t3_fourth_ignored", ringing, 1'b1);
        chk2("t3_count_max", snooze_count, 2'd3);

        // Invalid load is rejected; alarm 01:30 still fires afterwards.
        alarm_min_in = 6'd61; alarm_sec_in = 6'd0; alarm_load = 1'b1;
        step("t4_bad_load");
        chk1("t4_load_err", load_err, 1'b1);
        step("t4_err_clear");
        chk1("t4_load_err_pulse", load_err, 1'b0);
        dismiss = 1'b1;
        step("t4_dismiss");
        chk1("t4_dismissed", ringing, 1'b0);
        set_time(6'd1, 6'd29, "t4_pre");
        set_time(6'd1, 6'd30, "t4_match");
        chk1("t4_old_alarm_kept", ringing, 1'b1);
        alarm_min_in = 6'd0; alarm_sec_in = 6'd5; alarm_load = 1'b1;
        step("t4_load_ringing");
        chk1("t4_state_kept", ringing, 1'b1);

        // Disable while snoozing, and while ringing.
        snooze = 1'b1;
        step("t5_snooze");
        alarm_enable = 1'b0;
        step("t5_disable_snz");
        chk1("t5_armed_off", armed, 1'b0);
        chk2("t5_count_clr", snooze_count, 2'd0);
        alarm_enable = 1'b1;
        step("t5_reenable");
        set_time(6'd0, 6'd4, "t5_pre");
        set_time(6'd0, 6'd5, "t5_match");
        chk1("t5_ring_new_alarm", ringing, 1'b1);
        alarm_enable = 1'b0;
        step("t5_disable_ring");
        chk1("t5_ring_off", ringing, 1'b0);
        chk1("t5_armed_off2", armed, 1'b0);
        alarm_enable = 1'b1;
        step("t5_reenable2");

        // Held time at the match value rings once and never re-triggers.
        set_time(6'd0, 6'd4, "t6_pre");
        set_time(6'd0, 6'd5, "t6_match");
        for (int i = 0; i < 10; i++) step("t6_hold");
        chk1("t6_still_ringing", ringing, 1'b1);
        dismiss = 1'b1;
        step("t6_dismiss");
        for (int i = 0; i < 5; i++) step("t6_hold_after");
        chk1("t6_no_retrigger", ringing, 1'b0);

        // Async reset in the middle of ringing.
        set_time(6'd0, 6'd4, "t6_pre2");
        set_time(6'd0, 6'd5, "t6_match2");
        chk1("t6_ringing_again", ringing, 1'b1);
        #3 reset = 1'b0;
        #1;
        chk1("t6_rst:ringing", ringing, 1'b0);
        chk1("t6_rst:armed", armed, 1'b0);
        chk2("t6_rst:snooze_count", snooze_count, 2'd0);
        chk1("t6_rst:missed", missed, 1'b0);
        model_reset();
        #2 reset = 1'b1;

        // Randomized traffic around the current minute.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 55) advance();
            else if (r == 99) seconds = 6'($urandom_range(0, 59));
            alarm_enable = ($urandom_range(0, 99) != 0);
            snooze       = ($urandom_range(0, 99) < 6);
            dismiss      = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 3) begin
                alarm_load   = 1'b1;
                alarm_min_in = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : minutes;
                alarm_sec_in = 6'($urandom_range(0, 63));
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
